// File: rtl/image_feeder.sv
// Raster-order frame reader feeding a downstream line-buffer window builder under credit flow control.
// Optional bottom-edge zero padding is built only when FEEDER_PAD_EN is defined.
module image_feeder #(
    parameter int unsigned IMG_WIDTH  = 480,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned NUM_LINES  = 7,
    parameter int unsigned ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        pixel,
    output logic              pixel_valid,
    input  logic              window_valid
);

    localparam int unsigned CAP   = NUM_LINES * IMG_WIDTH;
    localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned OCC_W = $clog2(CAP + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
`ifdef FEEDER_PAD_EN
        PAD,
`endif
        FLUSH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              pv_q;
    logic              pad_issue;
    logic              credit;
    logic [OCC_W:0]    occ_plus;

`ifdef FEEDER_PAD_EN
    localparam int unsigned PAD_N = 5 * IMG_WIDTH;
    localparam int unsigned PAD_W = $clog2(PAD_N + 1);
    logic [PAD_W-1:0] pad_cnt_q, pad_cnt_d;
    logic             pad_pix_q;
`endif

    // The pixel already in flight holds a slot, so it counts against the credit.
    assign occ_plus = {1'b0, occ_q} + {{OCC_W{1'b0}}, pv_q};
    assign credit   = occ_plus < (OCC_W + 1)'(CAP);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_rd_en = 1'b0;
        pad_issue = 1'b0;
        done      = 1'b0;
`ifdef FEEDER_PAD_EN
        pad_cnt_d = pad_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    addr_d  = '0;
                end
            end
            STREAM: begin
                if (credit) begin
                    mem_rd_en = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
`ifdef FEEDER_PAD_EN
                        state_d   = PAD;
                        pad_cnt_d = '0;
`else
                        state_d   = FLUSH;
`endif
                    end
                end
            end
`ifdef FEEDER_PAD_EN
            PAD: begin
                if (credit) begin
                    pad_issue = 1'b1;
                    pad_cnt_d = pad_cnt_q + 1'b1;
                    if (pad_cnt_q == PAD_W'(PAD_N - 1)) state_d = FLUSH;
                end
            end
`endif
            // Entered right after the final issue, so the last pixel leaves during this cycle.
            FLUSH:   state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (pv_q && !window_valid) begin
            occ_d = occ_q + 1'b1;
        end else if (!pv_q && window_valid && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            occ_q     <= '0;
            pv_q      <= 1'b0;
`ifdef FEEDER_PAD_EN
            pad_cnt_q <= '0;
            pad_pix_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            occ_q     <= occ_d;
            pv_q      <= mem_rd_en | pad_issue;
`ifdef FEEDER_PAD_EN
            pad_cnt_q <= pad_cnt_d;
            pad_pix_q <= pad_issue;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign mem_addr    = addr_q;
    assign pixel_valid = pv_q;
`ifdef FEEDER_PAD_EN
    assign pixel = (pv_q && !pad_pix_q) ? mem_rd_data : '0;
`else
    assign pixel = pv_q ? mem_rd_data : '0;
`endif

endmodule

// File: tb/tb_image_feeder.sv
module tb_image_feeder;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 10;
  localparam int unsigned NL    = 7;
  localparam int unsigned AW    = 7;
  localparam int          NPIX  = W * H;
  localparam int          CAP   = NL * W;
`ifdef FEEDER_PAD_EN
  localparam int          PADN  = 5 * W;
`else
  localparam int          PADN  = 0;
`endif
  localparam int          TOTAL = NPIX + PADN;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rd_data;
  logic [7:0]    pixel;
  logic          pixel_valid;
  logic          window_valid;

  logic [7:0] mem [0:(2**AW)-1];

  int checks = 0;
  int errors = 0;

  bit active;
  int frame_issued;
  int tot_issued;
  int tot_consumed;
  bit pending;
  bit pend_pad;
  int pend_addr;
  int done_count;
  int starts_accepted;
  int obs_pv;
  int first_pv;
  int last_pv;
  int cyc;

  image_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NUM_LINES (NL),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .window_valid(window_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    active       = 1'b0;
    frame_issued = 0;
    tot_issued   = 0;
    tot_consumed = 0;
    pending      = 1'b0;
    pend_pad     = 1'b0;
    pend_addr    = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < (2**AW); i++) mem[i] = 8'($urandom);
  endtask

  task automatic step(input int mode, input bit st);
    bit         credit;
    bit         exp_issue;
    bit         exp_rd;
    bit         exp_done;
    logic [7:0] exp_pix;
    case (mode)
      0:       window_valid = 1'b0;
      1:       window_valid = 1'b1;
      default: window_valid = 1'($urandom_range(0, 1));
    endcase
    start     = st;
    credit    = (tot_issued - tot_consumed) < CAP;
    exp_issue = active && (frame_issued < TOTAL) && credit;
    exp_rd    = exp_issue && (frame_issued < NPIX);
    exp_done  = active && (frame_issued == TOTAL) && !pending;
    exp_pix   = (pending && !pend_pad) ? mem[pend_addr] : 8'h00;

    chk("busy", busy === active, busy, active);
    chk("done", done === exp_done, done, exp_done);
    chk("rd_en", mem_rd_en === exp_rd, mem_rd_en, exp_rd);
    if (exp_rd) chk("addr", mem_addr === AW'(frame_issued), mem_addr, frame_issued);
    chk("pixel_valid", pixel_valid === pending, pixel_valid, pending);
    chk("pixel", pixel === exp_pix, pixel, exp_pix);

    if (pixel_valid) begin
      if (obs_pv == 0) first_pv = cyc;
      last_pv = cyc;
      obs_pv++;
    end

    if (window_valid && ((tot_issued - tot_consumed) > 0)) tot_consumed++;
    pending = exp_issue;
    if (exp_issue) begin
      pend_pad  = !exp_rd;
      pend_addr = frame_issued;
      tot_issued++;
      frame_issued++;
    end
    if (exp_done) begin
      active = 1'b0;
      done_count++;
    end else if (st && !active) begin
      active       = 1'b1;
      frame_issued = 0;
      starts_accepted++;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_frame(input int mode, input bit noisy_start);
    int n;
    n = 0;
    while (active && (n < 2000)) begin
      step(mode, noisy_start && ($urandom_range(0, 7) == 0));
      n++;
    end
    chk("frame_end_busy", busy === 1'b0, busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < CAP + 8; i++) step(1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    done_count      = 0;
    starts_accepted = 0;
    cyc             = 0;
    obs_pv          = 0;
    first_pv        = 0;
    last_pv         = 0;
    model_reset();
    fill_mem();
    reset        = 1'b1;
    start        = 1'b0;
    window_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_done", done === 1'b0, done, 0);
    chk("rst_rd_en", mem_rd_en === 1'b0, mem_rd_en, 0);
    chk("rst_addr", mem_addr === {AW{1'b0}}, mem_addr, 0);
    chk("rst_pv", pixel_valid === 1'b0, pixel_valid, 0);
    chk("rst_pixel", pixel === 8'h00, pixel, 0);
    reset = 1'b0;

    obs_pv = 0;
    step(0, 1'b1);
    for (int i = 0; i < 70; i++) step(0, 1'b0);
    chk("stall_count", obs_pv == CAP, obs_pv, CAP);
    chk("stall_busy", busy === 1'b1, busy, 1);
    for (int i = 0; i < 8; i++) step(1, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1'b0);
    chk("release_count", obs_pv == CAP + 8, obs_pv, CAP + 8);
    run_frame(2, 1'b0);
    chk("frame1_done", done_count == 1, done_count, 1);
    drain();

    fill_mem();
    obs_pv = 0;
    step(1, 1'b1);
    run_frame(1, 1'b0);
    chk("stream_count", obs_pv == TOTAL, obs_pv, TOTAL);
    chk("stream_span", (last_pv - first_pv + 1) == TOTAL, last_pv - first_pv + 1, TOTAL);
    chk("frame2_done", done_count == 2, done_count, 2);

    fill_mem();
    step(2, 1'b1);
    run_frame(2, 1'b1);
    chk("one_done_per_start", done_count == starts_accepted, done_count, starts_accepted);
    drain();

    step(1, 1'b1);
    for (int i = 0; (i < 200) && (frame_issued < 20); i++) step(1, 1'b0);
    chk("mid_addr", mem_addr === AW'(20), mem_addr, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy === 1'b0, busy, 0);
    chk("mid_rst_done", done === 1'b0, done, 0);
    chk("mid_rst_rd_en", mem_rd_en === 1'b0, mem_rd_en, 0);
    chk("mid_rst_addr", mem_addr === {AW{1'b0}}, mem_addr, 0);
    chk("mid_rst_pv", pixel_valid === 1'b0, pixel_valid, 0);
    chk("mid_rst_pixel", pixel === 8'h00, pixel, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_done", done === 1'b0, done, 0);
    model_reset();
    reset = 1'b0;
    fill_mem();
    step(2, 1'b1);
    chk("restart_addr", mem_addr === {AW{1'b0}}, mem_addr, 0);
    run_frame(2, 1'b0);
    chk("restart_done", done_count == starts_accepted - 1, done_count, starts_accepted - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
